regfile_wb_arbiter: RTL and testbench

Write-back arbiter on the register-file write side: collects results from `NR_SRC` functional units and drives the register file's `NR_WRITE_PORTS` write ports. Each source has a 2-entry buffer. Each cycle the arbiter grants up to `NR_WRITE_PORTS` buffer heads in round-robin order, discards writes to x0, never issues two same-cycle writes to one address, and registers the write-port outputs.

---
 rtl/regfile_wb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: per-source 2-entry result buffers, round-robin grant onto registered RF write ports.
// Optional REGFILE_WB_PERF_EN adds a saturating stall counter output (stall_cnt_o).
module regfile_wb_arbiter #(
    parameter int NR_SRC         = 3,
    parameter int NR_WRITE_PORTS = 2,
    parameter int DATA_WIDTH     = 64
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NR_SRC-1:0]                        src_valid_i,
    output logic [NR_SRC-1:0]                        src_ready_o,
    input  logic [NR_SRC-1:0][4:0]                   src_addr_i,
    input  logic [NR_SRC-1:0][DATA_WIDTH-1:0]        src_data_i,
    output logic [NR_WRITE_PORTS-1:0]                we_o,
    output logic [NR_WRITE_PORTS-1:0][4:0]           waddr_o,
    output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_o,
    output logic                                     idle_o
`ifdef REGFILE_WB_PERF_EN
    ,
    output logic [31:0]                              stall_cnt_o
`endif
);

    localparam int SRC_W = $clog2(NR_SRC);

    logic [4:0]            buf_addr [NR_SRC][2];
    logic [DATA_WIDTH-1:0] buf_data [NR_SRC][2];
    logic [NR_SRC-1:0]     head_q;
    logic [NR_SRC-1:0]     tail_q;
    logic [1:0]            count_q  [NR_SRC];
    logic                  ready_en_q;
    logic [SRC_W-1:0]      rr_ptr_q;
    logic [SRC_W-1:0]      rr_ptr_d;

    logic [NR_SRC-1:0]     push;
    logic [NR_SRC-1:0]     pop;
    logic [4:0]            head_addr [NR_SRC];
    logic [DATA_WIDTH-1:0] head_data [NR_SRC];
    logic [NR_SRC-1:0]     nonempty;

    logic [NR_WRITE_PORTS-1:0] grant_vld;
    logic [4:0]                grant_addr [NR_WRITE_PORTS];
    logic [DATA_WIDTH-1:0]     grant_data [NR_WRITE_PORTS];

    // ready_en_q keeps src_ready_o low in the cycle after a reset edge without a path from rst_i
    always_comb begin
        for (int unsigned s = 0; s < NR_SRC; s++) begin
            head_addr[s]   = buf_addr[s][head_q[s]];
            head_data[s]   = buf_data[s][head_q[s]];
            nonempty[s]    = (count_q[s] != 2'd0);
            src_ready_o[s] = ready_en_q && (count_q[s] < 2'd2);
        end
    end

    assign push   = src_valid_i & src_ready_o;
    assign idle_o = (nonempty == '0) && (we_o == '0);

    always_comb begin
        int unsigned      used;
        int unsigned      idx;
        logic [SRC_W-1:0] sidx;
        logic             conflict;
        pop       = '0;
        grant_vld = '0;
        rr_ptr_d  = rr_ptr_q;
        used      = 0;
        idx       = 0;
        sidx      = '0;
        conflict  = 1'b0;
        for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
            grant_addr[p] = '0;
            grant_data[p] = '0;
        end
        for (int unsigned i = 0; i < NR_SRC; i++) begin
            idx  = (32'(rr_ptr_q) + i) % NR_SRC;
            sidx = SRC_W'(idx);
            if (nonempty[sidx] && used < NR_WRITE_PORTS) begin
                if (head_addr[sidx] == 5'd0) begin
                    pop[sidx] = 1'b1;
                end else begin
                    conflict = 1'b0;
                    for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
                        if (p < used && grant_addr[p] == head_addr[sidx]) conflict = 1'b1;
                    end
                    if (!conflict) begin
                        for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
                            if (p == used) begin
                                grant_vld[p]  = 1'b1;
                                grant_addr[p] = head_addr[sidx];
                                grant_data[p] = head_data[sidx];
                            end
                        end
                        used      = used + 1;
                        pop[sidx] = 1'b1;
                        rr_ptr_d  = (sidx == SRC_W'(NR_SRC - 1)) ? '0 : sidx + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            ready_en_q <= 1'b0;
            rr_ptr_q   <= '0;
            we_o       <= '0;
            waddr_o    <= '0;
            wdata_o    <= '0;
            for (int unsigned s = 0; s < NR_SRC; s++) count_q[s] <= '0;
        end else begin
            ready_en_q <= 1'b1;
            rr_ptr_q   <= rr_ptr_d;
            for (int unsigned s = 0; s < NR_SRC; s++) begin
                if (push[s]) tail_q[s] <= ~tail_q[s];
                if (pop[s])  head_q[s] <= ~head_q[s];
                case ({push[s], pop[s]})
                    2'b10:   count_q[s] <= count_q[s] + 2'd1;
                    2'b01:   count_q[s] <= count_q[s] - 2'd1;
                    default: count_q[s] <= count_q[s];
                endcase
            end
            for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
                we_o[p] <= grant_vld[p];
                if (grant_vld[p]) begin
                    waddr_o[p] <= grant_addr[p];
                    wdata_o[p] <= grant_data[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned s = 0; s < NR_SRC; s++) begin
            if (push[s]) begin
                buf_addr[s][tail_q[s]] <= src_addr_i[s];
                buf_data[s][tail_q[s]] <= src_data_i[s];
            end
        end
    end

`ifdef REGFILE_WB_PERF_EN
    logic stall;

    // A stall is any non-x0 head that survives the cycle, whether deferred or out of ports
    always_comb begin
        stall = 1'b0;
        for (int unsigned s = 0; s < NR_SRC; s++) begin
            if (nonempty[s] && head_addr[s] != 5'd0 && !pop[s]) stall = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (3 sources, 2 write ports, 64-bit data).
module tb_regfile_wb_arbiter;

    localparam int NS = 3;
    localparam int NP = 2;
    localparam int DW = 64;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NS-1:0]             src_valid = '0;
    logic [NS-1:0]             src_ready;
    logic [NS-1:0][4:0]        src_addr = '0;
    logic [NS-1:0][DW-1:0]     src_data = '0;
    logic [NP-1:0]             we;
    logic [NP-1:0][4:0]        waddr;
    logic [NP-1:0][DW-1:0]     wdata;
    logic                      idle;
`ifdef REGFILE_WB_PERF_EN
    logic [31:0]               stall_cnt;
    logic [31:0]               stall_before;
`endif

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(
        .NR_SRC(NS),
        .NR_WRITE_PORTS(NP),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .src_valid_i(src_valid),
        .src_ready_o(src_ready),
        .src_addr_i(src_addr),
        .src_data_i(src_data),
        .we_o(we),
        .waddr_o(waddr),
        .wdata_o(wdata),
        .idle_o(idle)
`ifdef REGFILE_WB_PERF_EN
        ,
        .stall_cnt_o(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        src_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (we !== 2'b00) begin errors++; $display("FAIL rst_we: got %b expected %b", we, 2'b00); end
        checks++; if (src_ready !== 3'b000) begin errors++; $display("FAIL rst_ready: got %b expected %b", src_ready, 3'b000); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", idle); end
        checks++; if (waddr !== '0 || wdata !== '0) begin errors++; $display("FAIL rst_wport: got %h/%h expected 0", waddr, wdata); end
        rst = 1'b0;
        tick();
        checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL idle_ready: got %b expected %b", src_ready, 3'b111); end
        checks++; if (we !== 2'b00 || idle !== 1'b1) begin errors++; $display("FAIL idle_we: got we=%b idle=%b expected we=00 idle=1", we, idle); end
    endtask

    task automatic test_single_write();
        src_valid = 3'b001;
        src_addr[0] = 5'd1;
        src_data[0] = 64'd924232;
        tick();
        src_valid = '0;
        checks++; if (we !== 2'b00 || idle !== 1'b0) begin errors++; $display("FAIL single_lat: got we=%b idle=%b expected we=00 idle=0", we, idle); end
        tick();
        checks++; if (we !== 2'b01) begin errors++; $display("FAIL single_we: got %b expected %b", we, 2'b01); end
        checks++; if (waddr[0] !== 5'd1 || wdata[0] !== 64'd924232) begin errors++; $display("FAIL single_wport: got %0d/%0d expected 1/924232", waddr[0], wdata[0]); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", idle); end
        tick();
        checks++; if (we !== 2'b00 || idle !== 1'b1) begin errors++; $display("FAIL single_idle: got we=%b idle=%b expected we=00 idle=1", we, idle); end
    endtask

    task automatic test_three_sources();
        pulse_reset();
        src_valid = 3'b111;
        src_addr[0] = 5'd13; src_data[0] = 64'hA13;
        src_addr[1] = 5'd14; src_data[1] = 64'hA14;
        src_addr[2] = 5'd15; src_data[2] = 64'hA15;
        tick();
        src_valid = '0;
        tick();
        checks++; if (we !== 2'b11) begin errors++; $display("FAIL three_we1: got %b expected %b", we, 2'b11); end
        checks++; if (waddr[0] !== 5'd13 || waddr[1] !== 5'd14) begin errors++; $display("FAIL three_addr1: got %0d,%0d expected 13,14", waddr[0], waddr[1]); end
        checks++; if (wdata[0] !== 64'hA13 || wdata[1] !== 64'hA14) begin errors++; $display("FAIL three_data1: got %h,%h expected a13,a14", wdata[0], wdata[1]); end
        tick();
        checks++; if (we !== 2'b01) begin errors++; $display("FAIL three_we2: got %b expected %b", we, 2'b01); end
        checks++; if (waddr[0] !== 5'd15 || wdata[0] !== 64'hA15) begin errors++; $display("FAIL three_port0_2: got %0d/%h expected 15/a15", waddr[0], wdata[0]); end
        checks++; if (waddr[1] !== 5'd14 || wdata[1] !== 64'hA14) begin errors++; $display("FAIL three_port1_hold: got %0d/%h expected 14/a14", waddr[1], wdata[1]); end
        tick();
        checks++; if (we !== 2'b00 || idle !== 1'b1) begin errors++; $display("FAIL three_idle: got we=%b idle=%b expected we=00 idle=1", we, idle); end
    endtask

    // rr_ptr is 0 on entry; src0 must win the first conflict cycle
    task automatic test_conflict();
`ifdef REGFILE_WB_PERF_EN
        stall_before = stall_cnt;
`endif
        src_valid = 3'b011;
        src_addr[0] = 5'd5; src_data[0] = 64'd1000;
        src_addr[1] = 5'd5; src_data[1] = 64'd1234;
        tick();
        src_valid = '0;
        tick();
        checks++; if (we !== 2'b01) begin errors++; $display("FAIL conf_we1: got %b expected %b", we, 2'b01); end
        checks++; if (waddr[0] !== 5'd5 || wdata[0] !== 64'd1000) begin errors++; $display("FAIL conf_first: got %0d/%0d expected 5/1000", waddr[0], wdata[0]); end
        tick();
        checks++; if (we !== 2'b01) begin errors++; $display("FAIL conf_we2: got %b expected %b", we, 2'b01); end
        checks++; if (waddr[0] !== 5'd5 || wdata[0] !== 64'd1234) begin errors++; $display("FAIL conf_second: got %0d/%0d expected 5/1234", waddr[0], wdata[0]); end
        tick();
        checks++; if (we !== 2'b00 || idle !== 1'b1) begin errors++; $display("FAIL conf_idle: got we=%b idle=%b expected we=00 idle=1", we, idle); end
`ifdef REGFILE_WB_PERF_EN
        checks++; if (stall_cnt !== stall_before + 32'd1) begin errors++; $display("FAIL conf_stall: got %0d expected %0d", stall_cnt, stall_before + 32'd1); end
`endif
    endtask

    // rr_ptr is 2 on entry
    task automatic test_x0_discard();
        src_valid = 3'b011;
        src_addr[0] = 5'd2; src_data[0] = 64'd77;
        src_addr[1] = 5'd0; src_data[1] = 64'hDEAD;
        tick();
        src_valid = '0;
        tick();
        checks++; if (we !== 2'b01) begin errors++; $display("FAIL x0_we: got %b expected %b", we, 2'b01); end
        checks++; if (waddr[0] !== 5'd2 || wdata[0] !== 64'd77) begin errors++; $display("FAIL x0_port0: got %0d/%0d expected 2/77", waddr[0], wdata[0]); end
        tick();
        checks++; if (we !== 2'b00 || idle !== 1'b1) begin errors++; $display("FAIL x0_empty: got we=%b idle=%b expected we=00 idle=1", we, idle); end
    endtask

    // rr_ptr is 1 on entry; src1/src2 grab both ports first, src0 fills up
    task automatic test_back_to_back();
        src_valid = 3'b111;
        src_addr[0] = 5'd20; src_data[0] = 64'd20;
        src_addr[1] = 5'd10; src_data[1] = 64'd10;
        src_addr[2] = 5'd11; src_data[2] = 64'd11;
        tick();
        checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL bp_ready0: got %b expected %b", src_ready, 3'b111); end
        src_addr[0] = 5'd21; src_data[0] = 64'd21;
        tick();
        checks++; if (src_ready !== 3'b110) begin errors++; $display("FAIL bp_ready1: got %b expected %b", src_ready, 3'b110); end
        checks++; if (we !== 2'b11 || waddr[0] !== 5'd10 || waddr[1] !== 5'd11) begin errors++; $display("FAIL bp_wr1: got we=%b addr=%0d,%0d expected we=11 addr=10,11", we, waddr[0], waddr[1]); end
        src_addr[0] = 5'd22; src_data[0] = 64'd22;
        tick();
        checks++; if (src_ready !== 3'b011) begin errors++; $display("FAIL bp_ready2: got %b expected %b", src_ready, 3'b011); end
        checks++; if (we !== 2'b11 || waddr[0] !== 5'd20 || waddr[1] !== 5'd10) begin errors++; $display("FAIL bp_wr2: got we=%b addr=%0d,%0d expected we=11 addr=20,10", we, waddr[0], waddr[1]); end
        src_valid = '0;
        rst = 1'b1;
        tick();
        checks++; if (we !== 2'b00 || src_ready !== 3'b000 || idle !== 1'b1) begin errors++; $display("FAIL bp_rst: got we=%b ready=%b idle=%b expected 00/000/1", we, src_ready, idle); end
        rst = 1'b0;
        tick();
        checks++; if (we !== 2'b00 || src_ready !== 3'b111 || idle !== 1'b1) begin errors++; $display("FAIL bp_post1: got we=%b ready=%b idle=%b expected 00/111/1", we, src_ready, idle); end
        tick();
        checks++; if (we !== 2'b00 || idle !== 1'b1) begin errors++; $display("FAIL bp_post2: got we=%b idle=%b expected 00/1", we, idle); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_three_sources();
        test_conflict();
        test_x0_discard();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
